// File: rtl/tt_cmd_sequencer_if.sv
// Host/datapath bundle for tt_cmd_sequencer.
//   Host side    : in_byte, in_strobe, out_ack (in)  ; out_byte, out_valid, busy, err (out)
//   Datapath side: dp_done, dp_result (in)            ; dp_operands, dp_start (out)
// Modport slave is the sequencer's view; master is the view of whatever drives it.
interface tt_cmd_sequencer_if #(
  parameter int unsigned OPS = 2,
  parameter int unsigned RES = 2
);
  logic [7:0]       in_byte;
  logic             in_strobe;
  logic             out_ack;
  logic [8*OPS-1:0] dp_operands;
  logic             dp_start;
  logic             dp_done;
  logic [8*RES-1:0] dp_result;
  logic [7:0]       out_byte;
  logic             out_valid;
  logic             busy;
  logic             err;

  modport master (
    output in_byte, in_strobe, out_ack, dp_done, dp_result,
    input  dp_operands, dp_start, out_byte, out_valid, busy, err
  );

  modport slave (
    input  in_byte, in_strobe, out_ack, dp_done, dp_result,
    output dp_operands, dp_start, out_byte, out_valid, busy, err
  );
endinterface

// File: rtl/tt_cmd_sequencer.sv
// Byte-serial command sequencer between tile pins and a compute datapath.
// Collects OPS operand bytes (first byte = MSB) under a host strobe, pulses dp_start,
// waits for dp_done with a TIMEOUT-cycle limit, then returns RES result bytes (MSB first)
// paced by a host acknowledge.
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : tt_cmd_sequencer_if.slave (host byte/strobe/ack, datapath start/done, status)
module tt_cmd_sequencer #(
  parameter int unsigned OPS     = 2,
  parameter int unsigned RES     = 2,
  parameter int unsigned TIMEOUT = 255
) (
  input logic              clk,
  input logic              rst_n,
  tt_cmd_sequencer_if.slave bus
);

  typedef enum logic [2:0] {StIdle, StLoad, StStart, StWait, StSend} state_e;

  state_e           state_q, state_d;
  logic [2:0]       strb_sync_q, ack_sync_q;
  logic [8*OPS-1:0] ops_q, ops_d;
  logic [8*RES-1:0] res_q, res_d;
  logic [7:0]       out_byte_q, out_byte_d;
  logic             out_valid_q, out_valid_d;
  logic             err_q, err_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [7:0]       tmo_q, tmo_d;
  logic             strb_rise, ack_rise;

  // Two flops for metastability, third flop only for rising-edge detection.
  assign strb_rise = strb_sync_q[1] & ~strb_sync_q[2];
  assign ack_rise  = ack_sync_q[1] & ~ack_sync_q[2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      strb_sync_q <= '0;
      ack_sync_q  <= '0;
      ops_q       <= '0;
      res_q       <= '0;
      out_byte_q  <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
      tmo_q       <= '0;
    end else begin
      state_q     <= state_d;
      strb_sync_q <= {strb_sync_q[1:0], bus.in_strobe};
      ack_sync_q  <= {ack_sync_q[1:0], bus.out_ack};
      ops_q       <= ops_d;
      res_q       <= res_d;
      out_byte_q  <= out_byte_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
      tmo_q       <= tmo_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ops_d       = ops_q;
    res_d       = res_q;
    out_byte_d  = out_byte_q;
    out_valid_d = out_valid_q;
    err_d       = err_q;
    cnt_d       = cnt_q;
    tmo_d       = tmo_q;
    case (state_q)
      StIdle: begin
        if (strb_rise) begin
          // Operands shift in from the LSB end so the first byte ends up as the MSB.
          ops_d = (8*OPS)'(bus.in_byte);
          err_d = 1'b0;
          if (OPS == 1) begin
            state_d = StStart;
          end else begin
            cnt_d   = 3'd1;
            state_d = StLoad;
          end
        end
      end
      StLoad: begin
        if (strb_rise) begin
          ops_d = (ops_q << 8) | (8*OPS)'(bus.in_byte);
          if (cnt_q == 3'(OPS - 1)) begin
            state_d = StStart;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end
      StStart: begin
        if (strb_rise) err_d = 1'b1;
        tmo_d   = '0;
        state_d = StWait;
      end
      StWait: begin
        if (strb_rise) err_d = 1'b1;
        if (bus.dp_done) begin
          res_d       = bus.dp_result;
          out_byte_d  = bus.dp_result[8*RES-1 -: 8];
          out_valid_d = 1'b1;
          cnt_d       = '0;
          state_d     = StSend;
        end else if (tmo_q == 8'(TIMEOUT - 1)) begin
          // This is the TIMEOUT-th cycle in WAIT without completion.
          err_d   = 1'b1;
          state_d = StIdle;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      StSend: begin
        if (strb_rise) err_d = 1'b1;
        if (ack_rise) begin
          if (cnt_q == 3'(RES - 1)) begin
            out_valid_d = 1'b0;
            state_d     = StIdle;
          end else begin
            cnt_d      = cnt_q + 3'd1;
            res_d      = res_q << 8;
            out_byte_d = res_d[8*RES-1 -: 8];
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign bus.dp_operands = ops_q;
  // Decoded straight from the state register, so reset can never leave a start pulse behind.
  assign bus.dp_start    = (state_q == StStart);
  assign bus.out_byte    = out_byte_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.busy        = (state_q != StIdle);
  assign bus.err         = err_q;

endmodule

// File: tb/tb_tt_cmd_sequencer.sv
module tb_tt_cmd_sequencer;

  logic        clk;
  logic        rst_n;
  logic [7:0]  in_byte;
  logic        in_strobe;
  logic        out_ack;
  logic        dpa_done;
  logic [15:0] dpa_result;

  int          n_vec = 0;
  int          n_bad = 0;
  int          start_cnt = 0;
  int          model_lat = 5;
  logic [15:0] model_result = 16'h0000;
  logic        b_valid_seen = 1'b0;

  // Instance A: long timeout, answered by the datapath model.
  // Instance B: TIMEOUT=4, its datapath never completes.
  tt_cmd_sequencer_if #(.OPS(2), .RES(2)) ifa ();
  tt_cmd_sequencer_if #(.OPS(2), .RES(2)) ifb ();

  assign ifa.in_byte   = in_byte;
  assign ifa.in_strobe = in_strobe;
  assign ifa.out_ack   = out_ack;
  assign ifa.dp_done   = dpa_done;
  assign ifa.dp_result = dpa_result;
  assign ifb.in_byte   = in_byte;
  assign ifb.in_strobe = in_strobe;
  assign ifb.out_ack   = out_ack;
  assign ifb.dp_done   = 1'b0;
  assign ifb.dp_result = 16'h0000;

  tt_cmd_sequencer #(.OPS(2), .RES(2), .TIMEOUT(20)) u_dut_a (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (ifa)
  );

  tt_cmd_sequencer #(.OPS(2), .RES(2), .TIMEOUT(4)) u_dut_b (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Datapath model for instance A: done pulse model_lat negedges after the start pulse.
  initial begin
    dpa_done   = 1'b0;
    dpa_result = 16'h0000;
    forever begin
      @(negedge clk);
      if (ifa.dp_start === 1'b1) begin
        start_cnt++;
        @(negedge clk);
        check("start_width", {31'd0, ifa.dp_start}, 32'd0);
        repeat (model_lat - 1) @(negedge clk);
        dpa_done   = 1'b1;
        dpa_result = model_result;
        @(negedge clk);
        dpa_done   = 1'b0;
      end
    end
  end

  always @(negedge clk) if (ifb.out_valid === 1'b1) b_valid_seen = 1'b1;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    in_byte   = b;
    in_strobe = 1'b1;
    repeat (5) @(negedge clk);
    in_strobe = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic send_ack();
    @(negedge clk);
    out_ack = 1'b1;
    repeat (5) @(negedge clk);
    out_ack = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_valid();
    int k = 0;
    while (ifa.out_valid !== 1'b1 && k < 60) begin
      @(negedge clk);
      k++;
    end
    check("valid_wait", {31'd0, ifa.out_valid}, 32'd1);
  endtask

  task automatic finish_result(input logic [7:0] hi, input logic [7:0] lo);
    wait_valid();
    check("res_hi", {24'd0, ifa.out_byte}, {24'd0, hi});
    send_ack();
    check("res_lo", {24'd0, ifa.out_byte}, {24'd0, lo});
    check("valid_mid", {31'd0, ifa.out_valid}, 32'd1);
    send_ack();
    check("valid_end", {31'd0, ifa.out_valid}, 32'd0);
    check("busy_end", {31'd0, ifa.busy}, 32'd0);
    check("out_hold", {24'd0, ifa.out_byte}, {24'd0, lo});
  endtask

  typedef struct {
    logic [7:0]  op0;
    logic [7:0]  op1;
    logic [15:0] result;
    logic [15:0] exp_ops;
    logic [7:0]  exp_hi;
    logic [7:0]  exp_lo;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int s0;
    int k;
    vecs[0] = '{8'h12, 8'h34, 16'hABCD, 16'h1234, 8'hAB, 8'hCD};
    vecs[1] = '{8'hFF, 8'h00, 16'h0001, 16'hFF00, 8'h00, 8'h01};
    vecs[2] = '{8'h00, 8'h01, 16'hFFFF, 16'h0001, 8'hFF, 8'hFF};
    vecs[3] = '{8'hA5, 8'h5A, 16'h8001, 16'hA55A, 8'h80, 8'h01};

    in_byte   = 8'h00;
    in_strobe = 1'b0;
    out_ack   = 1'b0;
    rst_n     = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ops", {16'd0, ifa.dp_operands}, 32'd0);
    check("rst_start", {31'd0, ifa.dp_start}, 32'd0);
    check("rst_out_byte", {24'd0, ifa.out_byte}, 32'd0);
    check("rst_valid", {31'd0, ifa.out_valid}, 32'd0);
    check("rst_busy", {31'd0, ifa.busy}, 32'd0);
    check("rst_err", {31'd0, ifa.err}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Stray acks in IDLE.
    send_ack();
    send_ack();
    check("stray_busy", {31'd0, ifa.busy}, 32'd0);
    check("stray_err", {31'd0, ifa.err}, 32'd0);
    check("stray_valid", {31'd0, ifa.out_valid}, 32'd0);

    // Table-driven full commands.
    for (int i = 0; i < 4; i++) begin
      s0           = start_cnt;
      model_result = vecs[i].result;
      send_byte(vecs[i].op0);
      send_byte(vecs[i].op1);
      check("operands", {16'd0, ifa.dp_operands}, {16'd0, vecs[i].exp_ops});
      finish_result(vecs[i].exp_hi, vecs[i].exp_lo);
      check("err_clean", {31'd0, ifa.err}, 32'd0);
      check("start_count", start_cnt - s0, 32'd1);
    end

    // Synchronizer latency: capture on the third edge after the pin rises.
    model_result = 16'h9F61;
    @(negedge clk);
    in_byte   = 8'hC3;
    in_strobe = 1'b1;
    repeat (2) @(negedge clk);
    check("sync_pre_busy", {31'd0, ifa.busy}, 32'd0);
    @(negedge clk);
    check("sync_busy", {31'd0, ifa.busy}, 32'd1);
    check("sync_byte0", {24'd0, ifa.dp_operands[7:0]}, 32'h0000_00C3);
    repeat (2) @(negedge clk);
    in_strobe = 1'b0;
    repeat (3) @(negedge clk);
    in_byte   = 8'h3C;
    in_strobe = 1'b1;
    repeat (2) @(negedge clk);
    check("sync_start_pre", {31'd0, ifa.dp_start}, 32'd0);
    @(negedge clk);
    check("sync_start", {31'd0, ifa.dp_start}, 32'd1);
    check("sync_ops", {16'd0, ifa.dp_operands}, 32'h0000_C33C);
    @(negedge clk);
    check("sync_start_post", {31'd0, ifa.dp_start}, 32'd0);
    @(negedge clk);
    in_strobe = 1'b0;
    repeat (3) @(negedge clk);
    finish_result(8'h9F, 8'h61);

    // Timeout on instance B (err left set by earlier timeouts, cleared by first strobe).
    model_result = 16'h2468;
    send_byte(8'h11);
    check("tmo_err_cleared", {31'd0, ifb.err}, 32'd0);
    fork
      send_byte(8'h22);
      begin
        k = 0;
        while (ifb.dp_start !== 1'b1 && k < 40) begin
          @(negedge clk);
          k++;
        end
        check("tmo_start_seen", {31'd0, ifb.dp_start}, 32'd1);
        repeat (4) @(negedge clk);
        check("tmo_busy_pre", {31'd0, ifb.busy}, 32'd1);
        check("tmo_err_pre", {31'd0, ifb.err}, 32'd0);
        @(negedge clk);
        check("tmo_busy", {31'd0, ifb.busy}, 32'd0);
        check("tmo_err", {31'd0, ifb.err}, 32'd1);
      end
    join
    finish_result(8'h24, 8'h68);
    check("tmo_no_valid", {31'd0, b_valid_seen}, 32'd0);

    // Overrun: third strobe lands while A waits for the datapath.
    model_lat    = 12;
    model_result = 16'hBEEF;
    send_byte(8'h12);
    send_byte(8'h34);
    send_byte(8'h56);
    check("ovr_err", {31'd0, ifa.err}, 32'd1);
    check("ovr_ops", {16'd0, ifa.dp_operands}, 32'h0000_1234);
    finish_result(8'hBE, 8'hEF);
    model_lat = 5;

    // Reset mid-LOAD.
    send_byte(8'h77);
    check("mid_busy", {31'd0, ifa.busy}, 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mr_ops", {16'd0, ifa.dp_operands}, 32'd0);
    check("mr_busy", {31'd0, ifa.busy}, 32'd0);
    check("mr_out_byte", {24'd0, ifa.out_byte}, 32'd0);
    check("mr_valid", {31'd0, ifa.out_valid}, 32'd0);
    check("mr_err", {31'd0, ifa.err}, 32'd0);
    check("mr_start", {31'd0, ifa.dp_start}, 32'd0);
    @(negedge clk);
    rst_n        = 1'b1;
    model_result = 16'h0F0E;
    send_byte(8'h01);
    send_byte(8'h02);
    check("mr_new_ops", {16'd0, ifa.dp_operands}, 32'h0000_0102);
    finish_result(8'h0F, 8'h0E);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
